up_counter_mod: RTL
===================

Name: up_counter_mod

Overview:
- Synchronous up-counter; the counting-up counterpart of the team's existing down counter.
- Counts from 0 to a programmable limit, then wraps (free-running mode) or stops (one-shot mode).
- Supports enable, parallel load, cascadable terminal-count output, sticky overflow flag and a done pulse.
- Used as a timer/prescaler building block in the sequential-counter library.

Parameters:
- N, 4, counter width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- load  input  1  synchronous parallel load.
- d  input  N  load value.
- limit  input  N  terminal value; q wraps (or stops) after reaching it.
- one_shot  input  1  mode select: 0 = free-running, 1 = one-shot.
- start  input  1  arms one-shot run (ignored in free mode).
- clr_ovf  input  1  clears ovf.
- q  output  N  registered count.
- tc  output  1  terminal count / carry-out, combinational.
- busy  output  1  one-shot run in progress.
- done  output  1  one-cycle pulse at one-shot completion.
- ovf  output  1  sticky wrap flag (free mode).

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst). All state updates on posedge clk.
- Reset: q=0, state=IDLE, busy=0, done=0, ovf=0. rst overrides every other input.
- Priority below rst: load > start > count. load sets q<=d next cycle in any state; state unchanged.
- Increment rule: if q >= limit, next q = 0 (wrap); else next q = q+1. Arithmetic is modulo 2^N. A loaded d > limit therefore wraps to 0 on the next count.
- FSM states: IDLE, RUN, DONE (busy = state==RUN).
- Free mode (one_shot=0):
  - State is forced to IDLE.
  - q increments on every cycle with en=1 and no load.
  - start is ignored.
  - ovf <= 1 on each wrap.
- One-shot mode (one_shot=1):
  - IDLE or DONE + start: q<=0, ->RUN.
  - RUN + en, q<limit: q<=q+1.
  - RUN + en, q>=limit: q holds, ->DONE.
  - DONE: q holds until start or load.
  - en=0 in RUN pauses counting.
  - Counting happens only in RUN.
- done: registered; high exactly in the first cycle state==DONE, low otherwise.
- tc = en & (q >= limit) & (~one_shot | state==RUN). Intended as carry-in (en) of the next cascaded stage.
- ovf: sticky. clr_ovf clears it; if a set and clr_ovf coincide, set wins.
- Switching one_shot 1->0 mid-RUN: state->IDLE next cycle, q continues counting per free mode, no done pulse.
- start during RUN: restarts (q<=0, stays RUN).
- limit=0:
  - Free mode: q stays 0, tc=en, ovf sets on the first en.
  - One-shot: start then one en cycle -> DONE.
- limit changed mid-count below current q: the next count wraps/terminates (>= compare).

Decomposition:
- Package counter_pkg holds:
  - typedef cnt_state_t {IDLE, RUN, DONE};
  - state encoding constants shared with the down counter's future one-shot variant.
- Single module; no sub-module. The limit comparator is inline logic.

Test Plan (N=4):
- Reset: rst=1 for 2 cycles with en=1, load=0 -> q=0, busy=0, done=0, ovf=0. Then rst=0, en=1 -> q=1 after 1 cycle.
- Free wrap: limit=15, en=1 for 20 cycles from 0 -> q 0..15,0..3; tc=1 only while q=15; ovf=1 from the cycle after the wrap. clr_ovf pulse -> ovf=0.
- Modulus/load:
  - limit=9 -> q 0..9,0,1.
  - load d=12 -> q=12, tc=1, next q=0.
  - load and en in the same cycle with d=5 -> q=5 (no increment).
- One-shot: one_shot=1, limit=5, start pulse, en=1 -> busy=1, q 0..5; then DONE, done=1 for exactly 1 cycle, q holds 5, busy=0. A second start -> q=0, RUN.
- Pause/mid-run reset:
  - In RUN at q=3, en=0 for 4 cycles -> q stays 3.
  - rst at q=3 -> q=0, IDLE, no done pulse.
  - one_shot 1->0 mid-RUN -> IDLE, counting continues.
- limit=0: free mode, en=1 -> q stays 0, tc=1 each cycle, ovf=1. One-shot: start, en -> done after 1 count cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state types and encodings for the sequential counter library
package counter_pkg;

    // Fixed encodings so the up counter and a future one-shot down counter agree
    localparam logic [1:0] CNT_ST_IDLE = 2'd0;
    localparam logic [1:0] CNT_ST_RUN  = 2'd1;
    localparam logic [1:0] CNT_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = CNT_ST_IDLE,
        RUN  = CNT_ST_RUN,
        DONE = CNT_ST_DONE
    } cnt_state_t;

endpackage

// File: rtl/up_counter_mod.sv
// rtl/up_counter_mod.sv - up-counter with programmable limit, free-running or one-shot
module up_counter_mod
    import counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic [N-1:0] limit,
    input  logic         one_shot,
    input  logic         start,
    input  logic         clr_ovf,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    cnt_state_t   state, state_n;
    logic [N-1:0] q_n;
    logic         done_n;
    logic         ovf_set;
    logic         at_lim;

    // >= rather than == so a lowered limit or an out-of-range load still terminates
    assign at_lim = (q >= limit);
    assign tc     = en & at_lim & (~one_shot | (state == RUN));
    assign busy   = (state == RUN);

    always_comb begin
        q_n     = q;
        state_n = state;
        ovf_set = 1'b0;
        if (!one_shot) begin
            state_n = IDLE;
            if (load) begin
                q_n = d;
            end else if (en) begin
                q_n     = at_lim ? '0 : q + 1'b1;
                ovf_set = at_lim;
            end
        end else begin
            if (load) begin
                q_n = d;
            end else if (start) begin
                q_n     = '0;
                state_n = RUN;
            end else if (state == RUN && en) begin
                if (at_lim) begin
                    state_n = DONE;
                end else begin
                    q_n = q + 1'b1;
                end
            end
        end
        done_n = (state_n == DONE) && (state != DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            state <= IDLE;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            q     <= q_n;
            state <= state_n;
            done  <= done_n;
            ovf   <= ovf_set | (ovf & ~clr_ovf);
        end
    end

endmodule
